f1_light_sequencer: RTL and testbench
=====================================

# f1_light_sequencer

Controller for the Formula-1 reaction-test experiment: sequences a row of ten lights on one at a time at a fixed tick interval, then holds all lights on for a pseudo-random number of ticks supplied by the LFSR, then extinguishes them and signals "go". The block owns its own tick counter, so it sequences the interval timing that a stand-alone delay counter would otherwise provide. It sits between the 1 ms tick generator and LFSR on one side and the LEDs and reaction timer on the other.

## Interface
- CNT_BITS, 14, width of the internal tick counter and of `rand_delay`
- STEP_TICKS, 500, ticks between successive lights coming on; legal range 1 .. 2^CNT_BITS-1
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `tick`  in  1  one-cycle timebase strobe (1 ms); may be high on consecutive cycles
- `start`  in  1  begin a sequence; level sampled each cycle, acted on only in IDLE
- `abort`  in  1  cancel the sequence and return to IDLE
- `rand_delay`  in  CNT_BITS  hold duration in ticks; sampled once, as the tenth light comes on
- `ledr`  out  10  light outputs; `ledr[0]` lights first
- `busy`  out  1  high in any state other than IDLE
- `go`  out  1  one-cycle pulse when the lights go out

## Operation
- Reset (asynchronous, any state): state=IDLE; `ledr`=0, `busy`=0, `go`=0; count=0; hold=0.
- States: IDLE, LIGHTS, HOLD. Priority each edge: `rst` > `abort` > state logic.
- IDLE:
  - `start`=1 → LIGHTS; `ledr`←10'b0000000001; count←0.
  - A `tick` in the same cycle is not counted.
- LIGHTS, on `tick`:
  - If count==STEP_TICKS-1: count←0; `ledr`←{`ledr`[8:0],1'b1}.
  - If the old `ledr[8]`==1 (this edge lights the tenth light): → HOLD; hold←(`rand_delay`==0 ? 1 : `rand_delay`).
  - Otherwise: count←count+1.
- HOLD, on `tick`:
  - If count==hold-1: `ledr`←0; `go`←1; count←0; → IDLE.
  - Otherwise: count←count+1.
- `go` is registered, high for exactly one cycle, and coincides with the first cycle of `ledr`==0.
- Cycles without `tick` leave count, `ledr` and state unchanged.
- `abort`=1 in LIGHTS or HOLD → IDLE; `ledr`←0; count←0; no `go`. `abort` in IDLE has no effect.
- `start` while `busy`=1 is ignored; there is no queuing.
- `start` held high through the `go` edge starts a new sequence on the next cycle, because the state is IDLE then.
- Width rules:
  - count and hold are CNT_BITS wide, unsigned.
  - Comparisons are equality only; count never exceeds its terminal value, so it cannot wrap.
  - `rand_delay`=0 is mapped to 1.

## Timing
- `start` sampled at edge E: `ledr`=1 and `busy`=1 from E.
- Light k (k=2..10) comes on at the edge of tick number (k-1)·STEP_TICKS after E.
- HOLD is entered on the same edge that lights the tenth light.
- `go` and `ledr`=0 occur at the edge of tick 9·STEP_TICKS + R, where R = max(`rand_delay`,1) sampled at HOLD entry.
- `busy` falls on the same edge that `go` rises.
- Changes to `rand_delay` after the sampling edge have no effect.
- Output latency from a qualifying `tick` is one edge. There is no combinational path from inputs to outputs.

## Test plan
- Reset mid-HOLD: assert `rst` asynchronously, between edges → `ledr`=0, `busy`=0, `go`=0 immediately; the next `start` sequences from light 1.
- Basic sequence: STEP_TICKS=4, `tick` tied high, `rand_delay`=5, `start` pulsed at edge 0 → `ledr` = 1, 3, 7, … at edges 0, 4, 8, …; `ledr`=10'h3FF at edge 36; `go`=1 and `ledr`=0 at edge 41 only; `busy` low from edge 41.
- Sparse ticks: `tick` every 3rd cycle, STEP_TICKS=2, `rand_delay`=1 → the second light comes on after 2 ticks (6 cycles); `go` after 19 ticks total; no change on non-tick cycles.
- Zero delay: `rand_delay`=0 at HOLD entry, then changed to 100 → `go` exactly 1 tick after the tenth light comes on.
- Abort, then start ignored: `abort` at light 6 → `ledr`=0, no `go`, IDLE. Then `start` pulses issued mid-sequence are ignored, and `start` held high through `go` restarts on the following cycle with `ledr`=1.
- Simultaneous `abort` and `start` in IDLE → enters LIGHTS. Simultaneous `abort` and terminal tick in HOLD → no `go`, `ledr`=0.

Source files
------------

// File: rtl/f1_light_sequencer.sv
// f1_light_sequencer
// Ten-light start sequencer: lights come on one per STEP_TICKS ticks, all ten
// are held for a pseudo-random number of ticks, then they go out and "go"
// pulses for one cycle. All outputs come from registers.
module f1_light_sequencer #(
    parameter int CNT_BITS   = 14,
    parameter int STEP_TICKS = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_BITS-1:0] rand_delay,
    output logic [9:0]          ledr,
    output logic                busy,
    output logic                go
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LIGHTS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] STEP_LAST = CNT_BITS'(STEP_TICKS - 1);
    localparam logic [CNT_BITS-1:0] ONE       = CNT_BITS'(1);

    state_t              state, state_n;
    logic [CNT_BITS-1:0] count, count_n;
    logic [CNT_BITS-1:0] hold, hold_n;
    logic [9:0]          ledr_n;
    logic                go_n;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            hold  <= '0;
            ledr  <= '0;
            go    <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            hold  <= hold_n;
            ledr  <= ledr_n;
            go    <= go_n;
        end
    end

    // Next-state logic: abort outranks the per-state sequencing.
    always_comb begin
        state_n = state;
        count_n = count;
        hold_n  = hold;
        ledr_n  = ledr;
        go_n    = 1'b0;

        if (abort && (state != IDLE)) begin
            state_n = IDLE;
            ledr_n  = '0;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n = LIGHTS;
                        ledr_n  = 10'b00_0000_0001;
                        count_n = '0;
                    end
                end
                LIGHTS: begin
                    if (tick) begin
                        if (count == STEP_LAST) begin
                            count_n = '0;
                            ledr_n  = {ledr[8:0], 1'b1};
                            // The edge that lights the tenth light also captures the hold time.
                            if (ledr[8]) begin
                                state_n = HOLD;
                                hold_n  = (rand_delay == '0) ? ONE : rand_delay;
                            end
                        end else begin
                            count_n = count + ONE;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (count == (hold - ONE)) begin
                            ledr_n  = '0;
                            go_n    = 1'b1;
                            count_n = '0;
                            state_n = IDLE;
                        end else begin
                            count_n = count + ONE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Busy is decoded from the state register only.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Testbench for f1_light_sequencer: table-driven vectors plus hand-written
// multi-cycle sequences, checked through an expected-value queue.
module tb_f1_light_sequencer;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        start;
    logic        abort;
    logic [13:0] rand_delay;
    logic [9:0]  ledr_a, ledr_b;
    logic        busy_a, busy_b;
    logic        go_a, go_b;

    int tests_run = 0;
    int tests_failed = 0;

    // Instance A: STEP_TICKS=4; instance B: STEP_TICKS=2. Both share inputs.
    f1_light_sequencer #(.CNT_BITS(14), .STEP_TICKS(4)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort),
        .rand_delay(rand_delay), .ledr(ledr_a), .busy(busy_a), .go(go_a)
    );

    f1_light_sequencer #(.CNT_BITS(14), .STEP_TICKS(2)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort),
        .rand_delay(rand_delay), .ledr(ledr_b), .busy(busy_b), .go(go_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] ledr;
        logic       busy;
        logic       go;
        int         sel;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        logic       t;
        logic       s;
        logic       a;
        logic [13:0] rd;
        logic [9:0] ledr;
        logic       busy;
        logic       go;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mk(input logic t, input logic s, input logic a,
                                input logic [13:0] rd, input logic [9:0] l,
                                input logic b, input logic g);
        vec_t v;
        v.t = t; v.s = s; v.a = a; v.rd = rd; v.ledr = l; v.busy = b; v.go = g;
        return v;
    endfunction

    function automatic logic [9:0] lights(input int k);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < k && i < 10; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic compare(input string nm, input int sel, input logic [9:0] el,
                           input logic eb, input logic eg);
        logic [9:0] al;
        logic       ab, ag;
        al = (sel == 0) ? ledr_a : ledr_b;
        ab = (sel == 0) ? busy_a : busy_b;
        ag = (sel == 0) ? go_a   : go_b;
        tests_run++;
        if (al !== el || ab !== eb || ag !== eg) begin
            tests_failed++;
            $display("FAIL %s @%0t: got ledr=%h busy=%b go=%b, expected ledr=%h busy=%b go=%b",
                     nm, $time, al, ab, ag, el, eb, eg);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic cyc(input logic t, input logic s, input logic a, input logic [13:0] rd,
                       input logic [9:0] el, input logic eb, input logic eg,
                       input int sel, input string nm);
        exp_t e;
        tick = t; start = s; abort = a; rand_delay = rd;
        e.ledr = el; e.busy = eb; e.go = eg; e.sel = sel;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sbq.pop_front();
            compare(nm, e.sel, e.ledr, e.busy, e.go);
        end
    endtask

    // Asynchronous reset between edges, checked before the next edge.
    task automatic do_reset();
        tick = 1'b0; start = 1'b0; abort = 1'b0; rand_delay = '0;
        rst = 1'b1;
        #2;
        compare("reset_a", 0, 10'h000, 1'b0, 1'b0);
        compare("reset_b", 1, 10'h000, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0; rand_delay = '0;

        // Table: idle behaviour, abort+start in IDLE, tick gating, abort in LIGHTS.
        vt[0]  = mk(1'b1, 1'b0, 1'b0, 14'd5, 10'h000, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 1'b0, 1'b1, 14'd5, 10'h000, 1'b0, 1'b0);
        vt[2]  = mk(1'b1, 1'b1, 1'b1, 14'd5, 10'h001, 1'b1, 1'b0);
        vt[3]  = mk(1'b0, 1'b0, 1'b0, 14'd5, 10'h001, 1'b1, 1'b0);
        vt[4]  = mk(1'b1, 1'b0, 1'b0, 14'd5, 10'h001, 1'b1, 1'b0);
        vt[5]  = mk(1'b1, 1'b0, 1'b0, 14'd5, 10'h001, 1'b1, 1'b0);
        vt[6]  = mk(1'b0, 1'b1, 1'b0, 14'd5, 10'h001, 1'b1, 1'b0);
        vt[7]  = mk(1'b1, 1'b0, 1'b0, 14'd5, 10'h001, 1'b1, 1'b0);
        vt[8]  = mk(1'b1, 1'b0, 1'b0, 14'd5, 10'h003, 1'b1, 1'b0);
        vt[9]  = mk(1'b0, 1'b0, 1'b1, 14'd5, 10'h000, 1'b0, 1'b0);
        vt[10] = mk(1'b1, 1'b0, 1'b0, 14'd5, 10'h000, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 11; i++)
            cyc(vt[i].t, vt[i].s, vt[i].a, vt[i].rd, vt[i].ledr, vt[i].busy, vt[i].go, 0, "table");

        // Basic sequence: STEP=4, tick always high, rand_delay=5.
        do_reset();
        for (int n = 0; n <= 42; n++) begin
            if (n <= 40)
                cyc(1'b1, n == 0, 1'b0, 14'd5, lights(imin(n / 4 + 1, 10)), 1'b1, 1'b0, 0, "basic");
            else if (n == 41)
                cyc(1'b1, 1'b0, 1'b0, 14'd5, 10'h000, 1'b0, 1'b1, 0, "basic_go");
            else
                cyc(1'b1, 1'b0, 1'b0, 14'd5, 10'h000, 1'b0, 1'b0, 0, "basic_after");
        end

        // Sparse ticks on instance B: tick every 3rd cycle, STEP=2, rand_delay=1.
        do_reset();
        for (int n = 0; n <= 58; n++) begin
            if (n < 57)
                cyc((n > 0) && (n % 3 == 0), n == 0, 1'b0, 14'd1,
                    lights(imin((n / 3) / 2 + 1, 10)), 1'b1, 1'b0, 1, "sparse");
            else if (n == 57)
                cyc(1'b1, 1'b0, 1'b0, 14'd1, 10'h000, 1'b0, 1'b1, 1, "sparse_go");
            else
                cyc(1'b0, 1'b0, 1'b0, 14'd1, 10'h000, 1'b0, 1'b0, 1, "sparse_after");
        end

        // Zero delay sampled at HOLD entry, then changed to 100.
        do_reset();
        for (int n = 0; n <= 38; n++) begin
            if (n <= 36)
                cyc(1'b1, n == 0, 1'b0, 14'd0, lights(imin(n / 4 + 1, 10)), 1'b1, 1'b0, 0, "zero");
            else if (n == 37)
                cyc(1'b1, 1'b0, 1'b0, 14'd100, 10'h000, 1'b0, 1'b1, 0, "zero_go");
            else
                cyc(1'b1, 1'b0, 1'b0, 14'd100, 10'h000, 1'b0, 1'b0, 0, "zero_after");
        end

        // Reset asserted asynchronously mid-HOLD, then a clean restart.
        do_reset();
        for (int n = 0; n <= 38; n++)
            cyc(1'b1, n == 0, 1'b0, 14'd20, lights(imin(n / 4 + 1, 10)), 1'b1, 1'b0, 0, "pre_rst");
        #3;
        rst = 1'b1;
        #1;
        compare("rst_async", 0, 10'h000, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 14'd20, 10'h001, 1'b1, 1'b0, 0, "rst_restart");
        cyc(1'b1, 1'b0, 1'b0, 14'd20, 10'h001, 1'b1, 1'b0, 0, "rst_restart2");

        // Abort at light 6, then ignored starts and start held through go.
        do_reset();
        for (int n = 0; n <= 22; n++) begin
            if (n < 22)
                cyc(1'b1, n == 0, 1'b0, 14'd5, lights(imin(n / 4 + 1, 10)), 1'b1, 1'b0, 0, "pre_abort");
            else
                cyc(1'b1, 1'b0, 1'b1, 14'd5, 10'h000, 1'b0, 1'b0, 0, "abort");
        end
        for (int n = 0; n < 3; n++)
            cyc(1'b1, 1'b0, 1'b0, 14'd5, 10'h000, 1'b0, 1'b0, 0, "abort_idle");
        for (int n = 0; n <= 40; n++) begin
            if (n <= 37)
                cyc(1'b1, (n == 0) || (n == 5) || (n == 10) || (n >= 37), 1'b0, 14'd2,
                    lights(imin(n / 4 + 1, 10)), 1'b1, 1'b0, 0, "start_ignored");
            else if (n == 38)
                cyc(1'b1, 1'b1, 1'b0, 14'd2, 10'h000, 1'b0, 1'b1, 0, "held_go");
            else
                cyc(1'b1, 1'b1, 1'b0, 14'd2, 10'h001, 1'b1, 1'b0, 0, "held_restart");
        end

        // Abort coinciding with the terminal HOLD tick: no go.
        do_reset();
        for (int n = 0; n <= 40; n++) begin
            if (n <= 38)
                cyc(1'b1, n == 0, 1'b0, 14'd3, lights(imin(n / 4 + 1, 10)), 1'b1, 1'b0, 0, "pre_hold_abort");
            else if (n == 39)
                cyc(1'b1, 1'b0, 1'b1, 14'd3, 10'h000, 1'b0, 1'b0, 0, "hold_abort");
            else
                cyc(1'b1, 1'b0, 1'b0, 14'd3, 10'h000, 1'b0, 1'b0, 0, "hold_abort_after");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
